sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//   Memory-stage responder for the control unit's mem_r_en/mem_w_en requests.
//   Turns each 32-bit data-memory read or write into two 16-bit accesses on an
//   external SRAM, low half first. While an access is in progress it deasserts
//   ready so the pipeline freezes, and it returns the assembled 32-bit read data.
// PARAMETERS
//   BASE_ADDR    1024  byte address that maps to SRAM word 0
//   WAIT_CYCLES  2     clock cycles per 16-bit SRAM access (>=1)
// PORTS
//   clk          in   1   single clock; everything updates on the rising edge
//   rst          in   1   synchronous, active-high reset
//   rd_en        in   1   read request (mem_r_en from the MEM stage)
//   wr_en        in   1   write request (mem_w_en from the MEM stage)
//   address      in   32  byte address (ALU result)
//   write_data   in   32  store data (Rm value)
//   read_data    out  32  loaded word; valid when ready=1 after a read
//   ready        out  1   0 = freeze pipeline, 1 = MEM stage may advance
//   sram_addr    out  18  SRAM half-word address
//   sram_dq_out  out  16  SRAM write data
//   sram_dq_oe   out  1   1 = controller drives the SRAM data bus
//   sram_dq_in   in   16  SRAM read data
//   sram_we_n    out  1   SRAM write enable, active low
// BEHAVIOUR
//   Address map: word = (address - BASE_ADDR) >> 2, computed mod 2^32 with no
//   range check; sram_addr = {word[16:0], half}, where half=0 is the low 16 bits.
//   FSM states: IDLE, LOW, HIGH, DONE.
//   - IDLE: if rd_en|wr_en, latch address, write_data and the op, clear the
//     counter, go to LOW. If both enables are set, the access is a read and the
//     write is dropped.
//   - LOW: sram_addr = {word,0}. For a write: sram_we_n=0, sram_dq_oe=1,
//     sram_dq_out = data[15:0]. Stay WAIT_CYCLES cycles. For a read, sample
//     sram_dq_in into read_data[15:0] on the last of those cycles. Then go to HIGH.
//   - HIGH: same as LOW with {word,1} and data[31:16]. Then go to DONE.
//   - DONE: one cycle, then go to IDLE. sram_we_n=1 and sram_dq_oe=0.
//   ready (combinational) = (IDLE & ~(rd_en|wr_en)) | DONE.
//   Latency: when a request is first seen in IDLE, ready is low for exactly
//   2*WAIT_CYCLES+1 cycles and is then high for the one DONE cycle. A request
//   still asserted in the cycle after DONE is treated as a new access.
//   A request dropped mid-access does not abort it; the access runs to DONE.
//   read_data holds its value until the next read overwrites it; writes leave
//   it unchanged.
//   Outside LOW/HIGH writes: sram_we_n=1 and sram_dq_oe=0.
//   sram_addr and sram_dq_out are don't-care when not used, but must be stable
//   during each half.
//   Reset: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0,
//   sram_we_n=1, sram_dq_oe=0. A reset mid-access aborts it with no further
//   SRAM write, and ready follows the IDLE rule on the next cycle.
// TESTING (WAIT_CYCLES=2, SRAM behavioural model)
//   Write 0xDEADBEEF to 0x408 -> SRAM[4]=0xBEEF, SRAM[5]=0xDEAD; ready low
//     for 5 cycles, then high for 1.
//   Read 0x408 after that write -> read_data=0xDEADBEEF when ready rises;
//     sram_we_n stays 1 throughout.
//   Back-to-back write then read held through DONE -> two separate 5-cycle
//     freezes; the SRAM is updated before the read returns 0xDEADBEEF.
//   rst asserted in the 2nd HIGH cycle of a write of 0x12345678 to 0x400 ->
//     SRAM[0]=0x5678, SRAM[1] unchanged; next cycle shows IDLE outputs and
//     read_data=0.
//   rd_en=wr_en=1 at 0x400 -> read performed, SRAM unchanged, data returned.
//   rd_en pulsed for 1 cycle only -> full 5-cycle access, then ready=1 and
//     read_data updated.

Source files
------------

// File: rtl/sram_controller_if.sv
// Pipeline MEM-stage request bus and external 16-bit SRAM pins for sram_controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit data-memory access into two 16-bit SRAM accesses (low half first),
// holding ready low so the pipeline freezes until the access completes.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  sram_controller_if.slave  bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [16:0]     word_q, word_d;
  logic [31:0]     data_q, data_d;
  logic            is_read_q, is_read_d;
  logic [31:0]     read_data_q, read_data_d;

  logic        req;
  logic        last;
  logic        active;
  logic [31:0] offset;
  logic        unused_offset;

  assign req    = bus.rd_en | bus.wr_en;
  assign last   = (cnt_q == CntLast);
  assign offset = bus.address - BASE_ADDR;
  // Only the 17-bit word index fits the SRAM; higher and byte-offset bits are dropped.
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_d      = data_q;
    is_read_d   = is_read_q;
    read_data_d = read_data_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          word_d    = offset[18:2];
          data_d    = bus.write_data;
          is_read_d = bus.rd_en;
          cnt_d     = '0;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (is_read_q) read_data_d[15:0] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
          if (is_read_q) read_data_d[31:16] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      data_q      <= '0;
      is_read_q   <= 1'b1;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      data_q      <= data_d;
      is_read_q   <= is_read_d;
      read_data_q <= read_data_d;
    end
  end

  assign active = (state_q == StLow) || (state_q == StHigh);

  assign bus.ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = {word_q, state_q == StHigh};
  assign bus.sram_dq_out = (state_q == StHigh) ? data_q[31:16] : data_q[15:0];
  assign bus.sram_dq_oe  = active & ~is_read_q;
  assign bus.sram_we_n   = ~(active & ~is_read_q);

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: behavioural SRAM plus a word-level reference memory, directed
// spec scenarios followed by randomized reads/writes.
module tb_sram_controller;

  localparam int unsigned Base = 1024;
  localparam int unsigned Wait = 2;
  localparam int unsigned Lat  = 2 * Wait + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sram_controller_if bus ();

  sram_controller #(
    .BASE_ADDR   (Base),
    .WAIT_CYCLES (Wait)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: a write lands only after a full Wait-cycle pulse at one address.
  bit [15:0] sram    [0:262143];
  bit [15:0] ref_mem [0:262143];
  int        wcnt;
  logic [17:0] waddr;

  assign bus.sram_dq_in = sram[bus.sram_addr];

  initial begin
    wcnt  = 0;
    waddr = '0;
  end

  always @(posedge clk) begin
    if (bus.sram_we_n !== 1'b0) begin
      wcnt <= 0;
    end else begin
      if (wcnt != 0 && bus.sram_addr == waddr) begin
        wcnt <= wcnt + 1;
        if (wcnt + 1 == Wait && !rst) sram[bus.sram_addr] <= bus.sram_dq_out;
      end else begin
        wcnt <= 1;
        if (Wait == 1 && !rst) sram[bus.sram_addr] <= bus.sram_dq_out;
      end
      waddr <= bus.sram_addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (observed=running required=finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lo_index(input logic [31:0] addr);
    logic [31:0] word;
    word = (addr - Base) >> 2;
    return (word % 131072) * 2;
  endfunction

  // Deassert requests at a negedge in IDLE and check the quiet bus.
  task automatic idle_check(input string tag);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    check({tag, "_idle_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_idle_we_n"}, 32'(bus.sram_we_n), 32'd1);
    check({tag, "_idle_oe"}, 32'(bus.sram_dq_oe), 32'd0);
  endtask

  // Starts at a negedge in IDLE; returns at negedge+1 of the DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit pulse, input string tag);
    int unsigned lows;
    int unsigned lo;
    bit          we_seen;
    bit          oe_bad;
    logic [31:0] exp_rd;
    lows    = 0;
    we_seen = 1'b0;
    oe_bad  = 1'b0;
    lo      = lo_index(addr);
    exp_rd  = {ref_mem[lo + 1], ref_mem[lo]};
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    #1;
    while (bus.ready !== 1'b1 && lows < 20) begin
      lows++;
      if (bus.sram_we_n !== 1'b1) we_seen = 1'b1;
      if (bus.sram_dq_oe !== ~bus.sram_we_n) oe_bad = 1'b1;
      @(negedge clk);
      if (pulse) begin
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
      end
      #1;
    end
    check({tag, "_latency"}, lows, Lat);
    check({tag, "_ready_done"}, 32'(bus.ready), 32'd1);
    check({tag, "_oe_vs_we"}, 32'(oe_bad), 32'd0);
    if (rd) begin
      check({tag, "_read_data"}, bus.read_data, exp_rd);
      check({tag, "_no_write"}, 32'(we_seen), 32'd0);
    end else begin
      ref_mem[lo]     = wdata[15:0];
      ref_mem[lo + 1] = wdata[31:16];
    end
    check({tag, "_sram_lo"}, 32'(sram[lo]), 32'(ref_mem[lo]));
    check({tag, "_sram_hi"}, 32'(sram[lo + 1]), 32'(ref_mem[lo + 1]));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_read_data", bus.read_data, 32'd0);
    check("reset_we_n", 32'(bus.sram_we_n), 32'd1);
    check("reset_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("reset_sram_addr", 32'(bus.sram_addr), 32'd0);
    check("reset_dq_out", 32'(bus.sram_dq_out), 32'd0);
    @(negedge clk);

    // Write then read at 0x408.
    access(1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, "wr408");
    check("wr408_sram4", 32'(sram[4]), 32'h0000BEEF);
    check("wr408_sram5", 32'(sram[5]), 32'h0000DEAD);
    @(negedge clk);
    idle_check("wr408");
    @(negedge clk);
    access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0, "rd408");
    check("rd408_value", bus.read_data, 32'hDEADBEEF);
    @(negedge clk);
    idle_check("rd408");
    @(negedge clk);

    // Back-to-back write then read, request never dropped.
    access(1'b0, 1'b1, 32'h40C, 32'hDEADBEEF, 1'b0, "b2b_wr");
    @(negedge clk);
    access(1'b1, 1'b0, 32'h40C, 32'h0, 1'b0, "b2b_rd");
    check("b2b_value", bus.read_data, 32'hDEADBEEF);
    @(negedge clk);
    idle_check("b2b");
    @(negedge clk);

    // Both enables: read wins, write dropped.
    access(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0, "wr400");
    @(negedge clk);
    access(1'b1, 1'b1, 32'h400, 32'h11112222, 1'b0, "both");
    check("both_value", bus.read_data, 32'hCAFEF00D);
    @(negedge clk);
    idle_check("both");
    @(negedge clk);

    // One-cycle read pulse still completes.
    access(1'b1, 1'b0, 32'h408, 32'h0, 1'b1, "pulse");
    check("pulse_value", bus.read_data, 32'hDEADBEEF);
    @(negedge clk);
    idle_check("pulse");
    @(negedge clk);

    // Reset in the second HIGH cycle of a write.
    bus.wr_en      = 1'b1;
    bus.address    = 32'h400;
    bus.write_data = 32'h12345678;
    repeat (4) @(negedge clk);
    #1;
    check("rstmid_we_n_high_half", 32'(bus.sram_we_n), 32'd0);
    check("rstmid_addr_high_half", 32'(bus.sram_addr), 32'd1);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    #1;
    ref_mem[0] = 16'h5678;
    check("rstmid_sram0", 32'(sram[0]), 32'h00005678);
    check("rstmid_sram1", 32'(sram[1]), 32'h0000CAFE);
    check("rstmid_ready", 32'(bus.ready), 32'd1);
    check("rstmid_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rstmid_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rstmid_read_data", bus.read_data, 32'd0);
    check("rstmid_sram_addr", 32'(bus.sram_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd_after_rst");
    @(negedge clk);
    idle_check("rd_after_rst");
    @(negedge clk);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      bit          rd;
      bit          wr;
      bit          pulse;
      logic [31:0] addr;
      rd    = 1'($urandom_range(0, 1));
      wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      pulse = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) addr = 32'h400 + 4 * $urandom_range(0, 15);
      else addr = $urandom;
      access(rd, wr, addr, $urandom, pulse, $sformatf("rnd%0d", i));
      @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        idle_check($sformatf("rnd%0d", i));
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
